// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_rf_pkg
//  Desc     : Shared defaults and types for the multi-port register file
//  Revision : 1.0  initial release
// ============================================================================
package riscv_rf_pkg;

   localparam int          DEF_XLEN     = 64;
   localparam int          DEF_NREGS    = 32;
   localparam int          SP_IDX       = 2;
   localparam logic [63:0] DEF_SP_RESET = 64'h38;

   // Address width for the default register count
   localparam int RF_AW = $clog2(DEF_NREGS);
   typedef logic [RF_AW-1:0] rf_addr_t;

endpackage
`default_nettype wire

// File: rtl/riscv_mprf_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mprf_if
//  Desc     : Read/write/reserve bus of the multi-port register file
//  Revision : 1.0  initial release
// ============================================================================
interface riscv_mprf_if #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2
) ();
   localparam int AW = $clog2(NREGS);

   logic [NWR-1:0]                i_riscv_mprf_we;
   logic [NWR-1:0][AW-1:0]        i_riscv_mprf_waddr;
   logic [NWR-1:0][XLEN-1:0]      i_riscv_mprf_wdata;
   logic [NRD-1:0][AW-1:0]        i_riscv_mprf_raddr;
   logic [NRD-1:0][XLEN-1:0]      o_riscv_mprf_rdata;
   logic [NRD-1:0]                o_riscv_mprf_rbusy;
   logic                          i_riscv_mprf_rsv;
   logic [AW-1:0]                 i_riscv_mprf_rsvaddr;
   logic                          i_riscv_mprf_flush;

   // Requester side (decode / writeback / test driver)
   modport master (
      output i_riscv_mprf_we, i_riscv_mprf_waddr, i_riscv_mprf_wdata,
      output i_riscv_mprf_raddr, i_riscv_mprf_rsv, i_riscv_mprf_rsvaddr,
      output i_riscv_mprf_flush,
      input  o_riscv_mprf_rdata, o_riscv_mprf_rbusy
   );

   // Register file side
   modport slave (
      input  i_riscv_mprf_we, i_riscv_mprf_waddr, i_riscv_mprf_wdata,
      input  i_riscv_mprf_raddr, i_riscv_mprf_rsv, i_riscv_mprf_rsvaddr,
      input  i_riscv_mprf_flush,
      output o_riscv_mprf_rdata, o_riscv_mprf_rbusy
   );
endinterface
`default_nettype wire

// File: rtl/riscv_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_rf_scoreboard
//  Desc     : Busy-bit tracker for pending register writebacks
//  Revision : 1.0  initial release
// ============================================================================
module riscv_rf_scoreboard
   import riscv_rf_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input  wire logic                       i_clk_n,
   input  wire logic                       i_rst,
   input  wire logic [NWR-1:0]             i_we,
   input  wire logic [NWR-1:0][$clog2(NREGS)-1:0] i_waddr,
   input  wire logic [NRD-1:0][$clog2(NREGS)-1:0] i_raddr,
   input  wire logic                       i_rsv,
   input  wire logic [$clog2(NREGS)-1:0]   i_rsvaddr,
   input  wire logic                       i_flush,
   input  wire logic                       i_byp_en,
   output logic      [NRD-1:0]             o_rbusy
);
   localparam int AW = $clog2(NREGS);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [NRD-1:0]   w_wr_hit;
   logic [NRD-1:0]   w_rsv_hit;

   // Next busy vector: writes clear, a reserve sets (new producer wins), flush clears all
   always_comb begin
      w_busy_nxt = r_busy;
      for (int p = 0; p < NWR; p++) begin
         if (i_we[p] && (i_waddr[p] != '0)) begin
            w_busy_nxt[i_waddr[p]] = 1'b0;
         end
      end
      if (i_rsv && (i_rsvaddr != '0)) begin
         w_busy_nxt[i_rsvaddr] = 1'b1;
      end
      if (i_flush) begin
         w_busy_nxt = '0;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Busy vector state, updated on the falling clock edge
   always_ff @(negedge i_clk_n or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // Per-read-port busy lookup; a forwarded write hides the stale busy bit
   always_comb begin
      o_rbusy   = '0;
      w_wr_hit  = '0;
      w_rsv_hit = '0;
      for (int r = 0; r < NRD; r++) begin
         for (int p = 0; p < NWR; p++) begin
            if (i_we[p] && (i_waddr[p] == i_raddr[r])) begin
               w_wr_hit[r] = 1'b1;
            end
         end
         w_rsv_hit[r] = i_rsv && (i_rsvaddr == i_raddr[r]);
         o_rbusy[r]   = r_busy[i_raddr[r]];
         if (i_byp_en && w_wr_hit[r] && !w_rsv_hit[r]) begin
            o_rbusy[r] = 1'b0;
         end
         if (i_raddr[r] == AW'(0)) begin
            o_rbusy[r] = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/riscv_mprf.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mprf
//  Desc     : Multi-port integer register file with bypass and scoreboard
//  Revision : 1.0  initial release
// ============================================================================
module riscv_mprf
   import riscv_rf_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter int              NREGS    = DEF_NREGS,
   parameter int              NRD      = 2,
   parameter int              NWR      = 2,
   parameter logic [XLEN-1:0] SP_RESET = XLEN'(DEF_SP_RESET),
   parameter bit              BYPASS   = 1'b1
) (
   input  wire logic   i_riscv_mprf_clk_n,
   input  wire logic   i_riscv_mprf_rst,
   riscv_mprf_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]           r_regs [NREGS];
   logic [NRD-1:0][XLEN-1:0]  w_rdata;
   logic [NRD-1:0]            w_rbusy;

   // Storage: reset loads SP, then ports apply in index order so the highest port wins
   always_ff @(negedge i_riscv_mprf_clk_n or posedge i_riscv_mprf_rst) begin
      if (i_riscv_mprf_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (bus.i_riscv_mprf_we[p] && (bus.i_riscv_mprf_waddr[p] != '0)) begin
               r_regs[bus.i_riscv_mprf_waddr[p]] <= bus.i_riscv_mprf_wdata[p];
            end
         end
      end
   end

   // Read muxes with optional same-cycle forwarding; x0 always reads zero
   always_comb begin
      w_rdata = '0;
      for (int r = 0; r < NRD; r++) begin
         w_rdata[r] = r_regs[bus.i_riscv_mprf_raddr[r]];
         if (BYPASS) begin
            for (int p = 0; p < NWR; p++) begin
               if (bus.i_riscv_mprf_we[p] &&
                   (bus.i_riscv_mprf_waddr[p] == bus.i_riscv_mprf_raddr[r])) begin
                  w_rdata[r] = bus.i_riscv_mprf_wdata[p];
               end
            end
         end
         if (bus.i_riscv_mprf_raddr[r] == AW'(0)) begin
            w_rdata[r] = '0;
         end
      end
   end

   riscv_rf_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) u_scoreboard (
      .i_clk_n   (i_riscv_mprf_clk_n),
      .i_rst     (i_riscv_mprf_rst),
      .i_we      (bus.i_riscv_mprf_we),
      .i_waddr   (bus.i_riscv_mprf_waddr),
      .i_raddr   (bus.i_riscv_mprf_raddr),
      .i_rsv     (bus.i_riscv_mprf_rsv),
      .i_rsvaddr (bus.i_riscv_mprf_rsvaddr),
      .i_flush   (bus.i_riscv_mprf_flush),
      .i_byp_en  (BYPASS),
      .o_rbusy   (w_rbusy)
   );

   assign bus.o_riscv_mprf_rdata = w_rdata;
   assign bus.o_riscv_mprf_rbusy = w_rbusy;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mprf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mprf
//  Desc     : Self-checking bench for riscv_mprf (bypass and non-bypass builds)
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_mprf;

   logic                 clk_n;
   logic                 rst;
   logic [1:0]           t_we;
   logic [1:0][4:0]      t_waddr;
   logic [1:0][63:0]     t_wdata;
   logic [1:0][4:0]      t_raddr;
   logic                 t_rsv;
   logic [4:0]           t_rsvaddr;
   logic                 t_flush;

   int errors = 0;
   int checks = 0;

   // Reference state: register contents and busy flags
   logic [63:0] m_reg  [32];
   bit          m_busy [32];

   riscv_mprf_if #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2)) bus_b ();
   riscv_mprf_if #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2)) bus_n ();

   assign bus_b.i_riscv_mprf_we      = t_we;
   assign bus_b.i_riscv_mprf_waddr   = t_waddr;
   assign bus_b.i_riscv_mprf_wdata   = t_wdata;
   assign bus_b.i_riscv_mprf_raddr   = t_raddr;
   assign bus_b.i_riscv_mprf_rsv     = t_rsv;
   assign bus_b.i_riscv_mprf_rsvaddr = t_rsvaddr;
   assign bus_b.i_riscv_mprf_flush   = t_flush;
   assign bus_n.i_riscv_mprf_we      = t_we;
   assign bus_n.i_riscv_mprf_waddr   = t_waddr;
   assign bus_n.i_riscv_mprf_wdata   = t_wdata;
   assign bus_n.i_riscv_mprf_raddr   = t_raddr;
   assign bus_n.i_riscv_mprf_rsv     = t_rsv;
   assign bus_n.i_riscv_mprf_rsvaddr = t_rsvaddr;
   assign bus_n.i_riscv_mprf_flush   = t_flush;

   riscv_mprf #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2),
                .SP_RESET(64'h38), .BYPASS(1'b1)) u_dut_byp (
      .i_riscv_mprf_clk_n (clk_n),
      .i_riscv_mprf_rst   (rst),
      .bus                (bus_b)
   );

   riscv_mprf #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2),
                .SP_RESET(64'h38), .BYPASS(1'b0)) u_dut_nobyp (
      .i_riscv_mprf_clk_n (clk_n),
      .i_riscv_mprf_rst   (rst),
      .bus                (bus_n)
   );

   initial begin
      clk_n = 1'b1;
      forever #5 clk_n = ~clk_n;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = (i == 2) ? 64'h38 : 64'h0;
         m_busy[i] = 1'b0;
      end
   endfunction

   // Register state seen from a read port, with optional forwarding
   function automatic logic [63:0] m_rd(input int a, input bit byp);
      logic [63:0] v;
      if (a == 0) return 64'h0;
      v = m_reg[a];
      if (byp)
         for (int p = 0; p < 2; p++)
            if (t_we[p] && int'(t_waddr[p]) == a) v = t_wdata[p];
      return v;
   endfunction

   function automatic logic m_rb(input int a, input bit byp);
      bit pending_wr;
      if (a == 0) return 1'b0;
      pending_wr = 1'b0;
      for (int p = 0; p < 2; p++)
         if (t_we[p] && int'(t_waddr[p]) == a) pending_wr = 1'b1;
      if (byp && pending_wr && !(t_rsv && int'(t_rsvaddr) == a)) return 1'b0;
      return m_busy[a];
   endfunction

   // Effect of one falling edge with the current inputs
   function automatic void m_edge();
      for (int p = 0; p < 2; p++) begin
         if (t_we[p] && t_waddr[p] != 5'd0) begin
            m_reg[t_waddr[p]]  = t_wdata[p];
            m_busy[t_waddr[p]] = 1'b0;
         end
      end
      if (t_rsv && t_rsvaddr != 5'd0) m_busy[t_rsvaddr] = 1'b1;
      if (t_flush)
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
   endfunction

   task automatic check_all(input string tag);
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("%s rdata_byp[%0d] a=%0d", tag, r, t_raddr[r]),
             bus_b.o_riscv_mprf_rdata[r], m_rd(int'(t_raddr[r]), 1'b1));
         chk($sformatf("%s rdata_nobyp[%0d] a=%0d", tag, r, t_raddr[r]),
             bus_n.o_riscv_mprf_rdata[r], m_rd(int'(t_raddr[r]), 1'b0));
         chk($sformatf("%s rbusy_byp[%0d] a=%0d", tag, r, t_raddr[r]),
             64'(bus_b.o_riscv_mprf_rbusy[r]), 64'(m_rb(int'(t_raddr[r]), 1'b1)));
         chk($sformatf("%s rbusy_nobyp[%0d] a=%0d", tag, r, t_raddr[r]),
             64'(bus_n.o_riscv_mprf_rbusy[r]), 64'(m_rb(int'(t_raddr[r]), 1'b0)));
      end
   endtask

   task automatic idle();
      t_we    = 2'b00;
      t_rsv   = 1'b0;
      t_flush = 1'b0;
   endtask

   // Check before and after one falling edge; inputs are held across it
   task automatic step(input string tag);
      @(posedge clk_n);
      check_all({tag, " pre"});
      @(negedge clk_n);
      m_edge();
      #1;
      check_all({tag, " post"});
   endtask

   initial begin
      rst = 1'b0;
      t_we = '0; t_waddr = '0; t_wdata = '0; t_raddr = '0;
      t_rsv = 1'b0; t_rsvaddr = '0; t_flush = 1'b0;

      // Reset state
      t_raddr[0] = 5'd2;
      t_raddr[1] = 5'd5;
      #1 rst = 1'b1;
      m_reset();
      #1;
      chk("reset rdata0", bus_b.o_riscv_mprf_rdata[0], 64'h38);
      chk("reset rdata1", bus_b.o_riscv_mprf_rdata[1], 64'h0);
      chk("reset rbusy", 64'(bus_b.o_riscv_mprf_rbusy), 64'h0);
      check_all("reset");
      @(negedge clk_n);
      #1 rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         t_raddr[0] = 5'(a);
         #1;
         chk($sformatf("sweep nonzero a=%0d", a),
             64'(bus_n.o_riscv_mprf_rdata[0] != 64'h0), 64'(a == 2));
         check_all("sweep");
      end
      @(negedge clk_n); #1;

      // Write-port collision and x0
      t_we = 2'b11; t_waddr[0] = 5'd7; t_waddr[1] = 5'd7;
      t_wdata[0] = 64'hAAAA; t_wdata[1] = 64'h5555; t_raddr[0] = 5'd7; t_raddr[1] = 5'd0;
      step("collide");
      idle(); #1;
      chk("collide reg7", bus_n.o_riscv_mprf_rdata[0], 64'h5555);
      t_we = 2'b01; t_waddr[0] = 5'd0; t_wdata[0] = 64'hFFFF; t_raddr[0] = 5'd0;
      step("x0 write");
      idle(); #1;
      chk("x0 reads zero", bus_n.o_riscv_mprf_rdata[0], 64'h0);

      // Bypass versus stored path
      t_raddr[0] = 5'd9;
      t_we = 2'b01; t_waddr[0] = 5'd9; t_wdata[0] = 64'h1234;
      @(posedge clk_n);
      chk("bypass pre", bus_b.o_riscv_mprf_rdata[0], 64'h1234);
      chk("nobypass pre", bus_n.o_riscv_mprf_rdata[0], 64'h0);
      @(negedge clk_n); m_edge(); #1;
      idle(); #1;
      chk("bypass post", bus_b.o_riscv_mprf_rdata[0], 64'h1234);
      chk("nobypass post", bus_n.o_riscv_mprf_rdata[0], 64'h1234);

      // Scoreboard reserve / clear interaction
      t_raddr[0] = 5'd12;
      t_rsv = 1'b1; t_rsvaddr = 5'd12;
      step("rsv12");
      idle(); #1;
      chk("rsv12 busy", 64'(bus_b.o_riscv_mprf_rbusy[0]), 64'h1);
      t_we = 2'b01; t_waddr[0] = 5'd12; t_wdata[0] = 64'h77;
      t_rsv = 1'b1; t_rsvaddr = 5'd12;
      step("wr+rsv12");
      idle(); #1;
      chk("wr+rsv12 busy", 64'(bus_n.o_riscv_mprf_rbusy[0]), 64'h1);
      t_we = 2'b10; t_waddr[1] = 5'd12; t_wdata[1] = 64'h88;
      @(posedge clk_n);
      chk("wr12 byp pre busy", 64'(bus_b.o_riscv_mprf_rbusy[0]), 64'h0);
      chk("wr12 nobyp pre busy", 64'(bus_n.o_riscv_mprf_rbusy[0]), 64'h1);
      @(negedge clk_n); m_edge(); #1;
      idle(); #1;
      chk("wr12 busy cleared", 64'(bus_n.o_riscv_mprf_rbusy[0]), 64'h0);

      // Flush beats a simultaneous reserve
      for (int a = 3; a <= 5; a++) begin
         t_rsv = 1'b1; t_rsvaddr = 5'(a); t_raddr[0] = 5'(a); t_raddr[1] = 5'd3;
         step("rsv chain");
      end
      t_rsv = 1'b1; t_rsvaddr = 5'd6; t_flush = 1'b1;
      step("flush");
      idle();
      for (int a = 3; a <= 6; a++) begin
         t_raddr[0] = 5'(a);
         #1;
         chk($sformatf("flush busy a=%0d", a), 64'(bus_n.o_riscv_mprf_rbusy[0]), 64'h0);
      end

      // Randomized traffic, collision-prone address range
      for (int n = 0; n < 300; n++) begin
         @(negedge clk_n); #1;
         t_we       = 2'($urandom);
         t_waddr[0] = 5'($urandom_range(0, 7));
         t_waddr[1] = 5'($urandom_range(0, 7));
         t_wdata[0] = {$urandom, $urandom};
         t_wdata[1] = {$urandom, $urandom};
         t_raddr[0] = 5'($urandom_range(0, 7));
         t_raddr[1] = 5'($urandom_range(0, 7));
         t_rsv      = ($urandom_range(0, 2) == 0);
         t_rsvaddr  = 5'($urandom_range(0, 7));
         t_flush    = ($urandom_range(0, 15) == 0);
         step("random");
      end

      // Asynchronous reset between edges with a write and a reserve pending
      @(negedge clk_n); #1;
      t_we = 2'b01; t_waddr[0] = 5'd10; t_wdata[0] = 64'hBEEF;
      t_rsv = 1'b1; t_rsvaddr = 5'd11; t_flush = 1'b0;
      t_raddr[0] = 5'd10; t_raddr[1] = 5'd11;
      #2 rst = 1'b1;
      m_reset();
      #1 check_all("midrst");
      @(negedge clk_n); #1;
      idle();
      rst = 1'b0;
      #1;
      chk("midrst reg10", bus_n.o_riscv_mprf_rdata[0], 64'h0);
      chk("midrst busy11", 64'(bus_b.o_riscv_mprf_rbusy[1]), 64'h0);
      t_raddr[1] = 5'd2;
      #1;
      chk("midrst sp", bus_b.o_riscv_mprf_rdata[1], 64'h38);
      check_all("midrst after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/riscv_mprf.md
# riscv_mprf

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It serves as the next-generation core register file. It provides NRD combinational read ports and NWR write ports with fixed write-port priority. It also provides optional write-to-read bypass and per-register busy tracking, so decode can stall on pending writebacks.

## Interface
- XLEN, 64, register width in bits
- NREGS, 32, register count; power of two, ≥ 4
- NRD, 2, read ports
- NWR, 2, write ports
- SP_RESET, 'h38, reset value of register 2 (stack pointer)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- AW, $clog2(NREGS), derived address width (localparam)
- i_riscv_mprf_clk_n  in  1  clock; all state updates on falling edge
- i_riscv_mprf_rst  in  1  asynchronous, active-high reset
- i_riscv_mprf_we  in  NWR  per-port write enable
- i_riscv_mprf_waddr  in  NWR×AW  per-port write address
- i_riscv_mprf_wdata  in  NWR×XLEN  per-port write data
- i_riscv_mprf_raddr  in  NRD×AW  per-port read address
- o_riscv_mprf_rdata  out  NRD×XLEN  per-port read data
- o_riscv_mprf_rbusy  out  NRD  busy bit of the register addressed by each read port
- i_riscv_mprf_rsv  in  1  reserve request: mark i_riscv_mprf_rsvaddr busy
- i_riscv_mprf_rsvaddr  in  AW  register to reserve
- i_riscv_mprf_flush  in  1  clear all busy bits (pipeline flush)

## Operation
- Storage: NREGS×XLEN array plus an NREGS-bit busy vector.
- Register 0:
  - Reads always return 0.
  - Writes to it are ignored.
  - It is never busy; reserve to 0 is ignored.
- Write:
  - On each falling edge, every port with we=1 and waddr≠0 updates its register.
  - If several ports target the same address, the highest-index port wins.
- Read:
  - Combinational. rdata = 0 if raddr = 0.
  - If BYPASS=1 and some port has we=1 with waddr = raddr ≠ 0, rdata takes that write data, using the highest-index matching port.
  - Otherwise rdata is the stored value.
- Scoreboard:
  - Any valid write (we=1, addr≠0) clears that register's busy bit at the falling edge.
  - rsv=1 sets busy[rsvaddr] at the falling edge.
  - If a clear and a set hit the same register in the same edge, set wins (new producer).
  - flush=1 clears all bits; flush has priority over rsv in the same edge.
  - Register writes still occur during flush.
- rbusy:
  - Combinational: busy[raddr], forced 0 for raddr = 0.
  - When BYPASS=1, rbusy is also forced 0 if a same-cycle write to raddr is present and no rsv to raddr is present.
- Out-of-range addresses cannot occur: NREGS is a power of two.

## Timing
- Reset (asynchronous, immediate):
  - All registers 0 except register 2 = SP_RESET.
  - Busy vector all 0.
  - rdata reflects reset contents combinationally: 0, or SP_RESET on ports addressing 2.
  - All rbusy outputs read 0.
- Write latency:
  - Data written at falling edge N is visible from stored state immediately after edge N.
  - With BYPASS=1 it is visible in the same cycle, before edge N.
- Reserve latency: busy is visible on rbusy right after the falling edge that sampled rsv.
- Reset asserted mid-cycle overrides pending writes, reserves and flush. No update occurs on the edge where rst is high.
- No handshake; every input is sampled on every falling edge.

## Structure
- Package riscv_rf_pkg holds:
  - Default XLEN and NREGS.
  - Localparam SP_IDX = 2 and the default SP_RESET.
  - Typedef rf_addr_t (logic [AW-1:0]).
- Sub-module riscv_rf_scoreboard owns the busy vector, the rsv/clear/flush priority logic and the rbusy lookup. Its parameters are NREGS, NRD and NWR.
- Top level holds the storage array, write-priority logic and read/bypass muxes.

## Test plan
- Reset check:
  - Assert rst with raddr = {2, 5}.
  - Required: rdata = {'h38, 0}, rbusy = {0, 0}.
  - Deassert rst and read all 32 registers; only register 2 is non-zero.
- Write-port collision:
  - Port0 writes reg 7 = 'hAAAA and port1 writes reg 7 = 'h5555 on the same edge.
  - Required: reg 7 reads 'h5555. Write x0 = 'hFFFF, then x0 still reads 0.
- Bypass:
  - With BYPASS=1, write reg 9 = 'h1234 while raddr0 = 9.
  - Required: rdata0 = 'h1234 before the edge.
  - With BYPASS=0, the same stimulus gives rdata0 = old value until after the edge.
- Scoreboard:
  - rsv reg 12, then rbusy = 1 on the next cycle.
  - Write reg 12 with rsv reg 12 on the same edge: busy stays 1.
  - Write reg 12 alone: busy goes to 0.
- Flush priority:
  - Reserve regs 3, 4 and 5, then assert flush together with rsv reg 6.
  - Required: all busy bits 0, including reg 6.
- Mid-operation reset:
  - Assert rst asynchronously between edges while we=1 to reg 10 = 'hBEEF and rsv reg 11.
  - Required: reg 10 = 0, busy[11] = 0, register 2 = 'h38.
